// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction-fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;

    // Fetch addresses are always word aligned; low two bits are forced to zero.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Brief    : Single-outstanding instruction fetch with a one-entry decode buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_stage
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    fetch_state_e state_q;
    logic         id_valid_q;
    logic [31:0]  id_instr_q;
    logic [31:0]  id_pc_q;

    logic         buf_free;
    logic         load_buf;

    assign buf_free  = !id_valid_q || id_ready;
    assign imem_addr = pc;
    assign imem_req  = !reset && (state_q == S_REQ) && buf_free && !redirect_valid;

    // A response is only accepted when the fetch it answers is still wanted.
    assign load_buf  = (state_q == S_WAIT) && imem_rvalid && !redirect_valid;

    always_comb begin
        pc_next = pc;
        if (reset) begin
            pc_next = RESET_PC;
        end else if (redirect_valid) begin
            pc_next = align_word(redirect_target);
        end else if (load_buf) begin
            pc_next = pc + INSTR_BYTES;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_REQ;
            id_valid_q <= 1'b0;
            id_instr_q <= 32'h0000_0000;
            id_pc_q    <= 32'h0000_0000;
        end else begin
            if (redirect_valid) begin
                id_valid_q <= 1'b0;
            end else if (load_buf) begin
                id_valid_q <= 1'b1;
                id_instr_q <= imem_rdata;
                id_pc_q    <= pc;
            end else if (id_ready) begin
                id_valid_q <= 1'b0;
            end

            unique case (state_q)
                S_REQ: begin
                    if (imem_req && imem_gnt) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_q <= S_REQ;
                    end else if (redirect_valid) begin
                        state_q <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

    assign id_valid = id_valid_q;
    assign id_instr = id_instr_q;
    assign id_pc    = id_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage with a behavioural fetch model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    int checks = 0;
    int failures = 0;

    // Behavioural model: "a fetch is in flight", "its answer is unwanted",
    // the decode buffer contents and the architectural PC register.
    logic        m_out = 1'b0;
    logic        m_stale = 1'b0;
    logic        m_vld = 1'b0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_idpc = 32'h0;
    logic [31:0] m_pc = 32'h0;
    logic        m_gr = 1'b0;

    assign pc = m_pc;

    always #5 clk = ~clk;

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .pc_next         (pc_next),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instr        (id_instr),
        .id_pc           (id_pc)
    );

    function automatic logic e_req();
        return !reset && !m_out && (!m_vld || id_ready) && !redirect_valid;
    endfunction

    function automatic logic [31:0] e_pcn();
        if (reset) return 32'h0;
        if (redirect_valid) return redirect_target & 32'hFFFF_FFFC;
        if (m_out && !m_stale && imem_rvalid) return m_pc + 32'd4;
        return m_pc;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_out <= 1'b0; m_stale <= 1'b0; m_vld <= 1'b0;
            m_instr <= 32'h0; m_idpc <= 32'h0; m_pc <= 32'h0; m_gr <= 1'b0;
        end else begin
            m_pc <= e_pcn();
            m_gr <= e_req() && imem_gnt;
            if (m_out && imem_rvalid) begin
                m_out <= 1'b0; m_stale <= 1'b0;
            end else if (m_out && redirect_valid) begin
                m_stale <= 1'b1;
            end else if (e_req() && imem_gnt) begin
                m_out <= 1'b1;
            end
            if (redirect_valid) begin
                m_vld <= 1'b0;
            end else if (m_out && !m_stale && imem_rvalid) begin
                m_vld <= 1'b1; m_instr <= imem_rdata; m_idpc <= m_pc;
            end else if (id_ready) begin
                m_vld <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("imem_req",  {31'h0, imem_req}, {31'h0, e_req()});
        chk("imem_addr", imem_addr, m_pc);
        chk("pc_next",   pc_next, e_pcn());
        chk("id_valid",  {31'h0, id_valid}, {31'h0, m_vld});
        if (m_vld) begin
            chk("id_instr", id_instr, m_instr);
            chk("id_pc",    id_pc, m_idpc);
        end
    end

    task automatic drive(input logic r, input logic g, input logic rv, input logic [31:0] rd,
                         input logic rdr, input logic [31:0] tg, input logic rdy);
        @(posedge clk); #1;
        reset = r; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        redirect_valid = rdr; redirect_target = tg; id_ready = rdy;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    initial begin
        logic       mem_active;
        int         mem_cnt;
        mem_active = 1'b0;
        mem_cnt = 0;

        repeat (2) drive(1, 0, 0, 0, 0, 0, 0);
        settle();
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_pcn", pc_next, 32'h0);
        chk("rst_vld", {31'h0, id_valid}, 32'h0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_idpc", id_pc, 32'h0);

        drive(0, 1, 0, 0, 0, 0, 0); settle();
        chk("first_req", {31'h0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        drive(0, 0, 1, 32'h0000_0013, 0, 0, 0); settle();
        chk("first_pcn", pc_next, 32'h4);

        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0); settle();
            chk("stall_vld", {31'h0, id_valid}, 32'h1);
            chk("stall_instr", id_instr, 32'h0000_0013);
            chk("stall_idpc", id_pc, 32'h0);
            chk("stall_req", {31'h0, imem_req}, 32'h0);
            chk("stall_pcn", pc_next, 32'h4);
        end
        drive(0, 1, 0, 0, 0, 0, 1); settle();
        chk("release_req", {31'h0, imem_req}, 32'h1);
        chk("release_addr", imem_addr, 32'h4);

        drive(0, 0, 0, 0, 1, 32'h0000_0100, 0); settle();
        chk("redir_pcn", pc_next, 32'h100);
        drive(0, 0, 0, 0, 0, 0, 0); settle();
        chk("drop_req", {31'h0, imem_req}, 32'h0);
        drive(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0); settle();
        chk("drop_pcn", pc_next, 32'h100);
        drive(0, 1, 0, 0, 0, 0, 0); settle();
        chk("after_drop_addr", imem_addr, 32'h100);
        chk("after_drop_vld", {31'h0, id_valid}, 32'h0);
        drive(0, 0, 1, 32'h1111_1111, 0, 0, 0); settle();
        chk("fetch100_pcn", pc_next, 32'h104);

        drive(0, 0, 0, 0, 1, 32'h0000_0203, 0); settle();
        chk("fetch100_idpc", id_pc, 32'h100);
        chk("fetch100_instr", id_instr, 32'h1111_1111);
        chk("align_pcn", pc_next, 32'h200);
        chk("redir_noreq", {31'h0, imem_req}, 32'h0);
        drive(0, 1, 0, 0, 0, 0, 0); settle();
        chk("align_addr", imem_addr, 32'h200);
        chk("redir_cleared", {31'h0, id_valid}, 32'h0);
        drive(0, 0, 1, 32'h0000_0022, 0, 0, 0); settle();

        drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0); settle();
        drive(0, 1, 0, 0, 0, 0, 0); settle();
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        drive(0, 0, 1, 32'h0000_0033, 0, 0, 0); settle();
        chk("wrap_pcn", pc_next, 32'h0);
        drive(0, 1, 0, 0, 0, 0, 1); settle();
        chk("wrap_idpc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0);

        drive(1, 0, 0, 0, 0, 0, 0); settle();
        chk("midrst_req", {31'h0, imem_req}, 32'h0);
        drive(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0); settle();
        chk("late_rsp_pcn", pc_next, 32'h0);
        drive(0, 1, 0, 0, 0, 0, 0); settle();
        chk("late_rsp_vld", {31'h0, id_valid}, 32'h0);
        chk("late_rsp_addr", imem_addr, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            if (m_gr) begin
                mem_active = 1'b1;
                mem_cnt = int'($urandom_range(0, 2));
            end
            imem_rvalid = 1'b0;
            if (mem_active) begin
                if (mem_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    mem_active = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end
            imem_rdata      = $urandom;
            reset           = ($urandom_range(0, 99) < 2);
            imem_gnt        = ($urandom_range(0, 99) < 70);
            redirect_valid  = ($urandom_range(0, 99) < 8);
            redirect_target = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : $urandom;
            id_ready        = ($urandom_range(0, 99) < 60);
        end

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL expose: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL expose: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL expose: pc  in  32  current PC from the program-counter register.
REQ-004 SHALL expose: pc_next  out  32  value loaded into the program-counter register every cycle.
REQ-005 SHALL expose: imem_req  out  1  fetch request to instruction memory.
REQ-006 SHALL expose: imem_addr  out  32  fetch address, equal to pc.
REQ-007 SHALL expose: imem_gnt  in  1  memory accepts the request in the cycle it is asserted with imem_req.
REQ-008 SHALL expose: imem_rvalid  in  1  response valid, at least one cycle after grant.
REQ-009 SHALL expose: imem_rdata  in  32  instruction word, qualified by imem_rvalid.
REQ-010 SHALL expose: redirect_valid  in  1  branch/jump/exception redirect request.
REQ-011 SHALL expose: redirect_target  in  32  redirect address.
REQ-012 SHALL expose: id_valid  out  1  decode-side instruction valid.
REQ-013 SHALL expose: id_ready  in  1  decode accepts the instruction when id_valid and id_ready are both high.
REQ-014 SHALL expose: id_instr, id_pc  out  32 each  fetched instruction and its address.

Function
REQ-015 SHALL implement FSM states S_REQ (issue), S_WAIT (await response), S_DROP (discard stale response).
REQ-016 SHALL keep a one-entry output buffer (id_valid/id_instr/id_pc); buffer "free" = !id_valid || id_ready.
REQ-017 SHALL drive imem_req = (state==S_REQ) && free && !redirect_valid; imem_addr = pc at all times.
REQ-018 S_REQ: imem_req && imem_gnt -> S_WAIT; otherwise stay; pc_next = pc.
REQ-019 S_WAIT: on imem_rvalid, load buffer with imem_rdata/pc, set id_valid, pc_next = pc + 4, -> S_REQ; otherwise pc_next = pc.
REQ-020 pc + 4 SHALL wrap modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-021 Handshake: id_ready while id_valid with no new load SHALL clear id_valid next cycle; simultaneous consume and load SHALL replace the entry, id_valid staying high.
REQ-022 id_instr/id_pc SHALL stay stable while id_valid && !id_ready.
REQ-023 Redirect (any state) SHALL set pc_next = {redirect_target[31:2], 2'b00} and clear id_valid next cycle, overriding REQ-018/019/021.
REQ-024 Redirect in S_REQ -> S_REQ (no request issued that cycle).
REQ-025 Redirect in S_WAIT without imem_rvalid -> S_DROP; with imem_rvalid the response SHALL be discarded, -> S_REQ.
REQ-026 S_DROP: imem_req = 0, pc_next = pc unless redirected; on imem_rvalid the response SHALL be discarded, -> S_REQ; redirect in S_DROP updates pc_next and stays S_DROP unless imem_rvalid.
REQ-027 At most one request SHALL be outstanding; throughput 1 instruction per 2 cycles with single-cycle grant and response.

Reset
REQ-028 Reset SHALL force state S_REQ, id_valid=0, id_instr=0, id_pc=0 on the next rising edge.
REQ-029 While reset is high: imem_req=0, pc_next=32'h0000_0000.
REQ-030 Reset mid-transaction SHALL abandon the outstanding fetch; a response arriving after reset SHALL be ignored in S_REQ (imem_rvalid in S_REQ has no effect).

Structure
REQ-031 Shared package fetch_pkg SHALL hold the state enum, INSTR_BYTES=4, and RESET_PC=32'h0000_0000.
REQ-032 Single module; no sub-module required (output buffer inline).

Verification
REQ-033 Reset, then gnt and rvalid each one cycle after request, rdata=0x00000013 -> id_valid with id_pc=0x0, id_instr=0x00000013; pc becomes 0x4.
REQ-034 id_ready=0 for 5 cycles with buffer full -> imem_req=0, id_instr/id_pc stable, pc unchanged; release -> next fetch at pc+4.
REQ-035 Redirect to 0x0000_0100 in S_WAIT, rvalid 2 cycles later with 0xDEADBEEF -> word dropped, next id_pc=0x100, never 0xDEADBEEF on id_instr.
REQ-036 Redirect to 0x0000_0203 -> next fetch address 0x0000_0200.
REQ-037 pc=0xFFFF_FFFC fetch completes -> pc_next=0x0000_0000.
REQ-038 reset asserted in S_WAIT, rvalid on the cycle after reset deasserts -> id_valid stays 0, first fetch at 0x0.
